// File: rtl/turing_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : turing_seq_ctrl                                              |
// | Description : Single-tape, 4-state/2-symbol Turing machine job sequencer.  |
// |               Optional step limit enabled by TURING_STEP_LIMIT_EN.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module turing_seq_ctrl #(
    parameter int HEAD_W = 4,
    parameter int STEP_W = 8,
    localparam int TAPE_W = 2**HEAD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [TAPE_W-1:0] start_tape,
    input  logic [HEAD_W-1:0] start_head,
    input  logic [STEP_W-1:0] start_max_steps,
    input  logic              tbl_we,
    input  logic [2:0]        tbl_addr,
    input  logic [5:0]        tbl_data,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [TAPE_W-1:0] res_tape,
    output logic [HEAD_W-1:0] res_head,
    output logic [1:0]        res_state,
    output logic [STEP_W-1:0] res_steps,
    output logic [1:0]        res_status
);

    localparam logic [1:0] c_ctrl_idle = 2'd0;
    localparam logic [1:0] c_ctrl_run  = 2'd1;
    localparam logic [1:0] c_ctrl_done = 2'd2;

    localparam logic [1:0] c_stat_halt = 2'b00;
    localparam logic [1:0] c_stat_off  = 2'b01;
    localparam logic [1:0] c_stat_tmo  = 2'b10;

    localparam logic [1:0] c_mv_right = 2'b01;
    localparam logic [1:0] c_mv_left  = 2'b10;

    localparam logic [HEAD_W-1:0] c_head_max  = '1;
    localparam logic [STEP_W-1:0] c_steps_max = '1;

    logic [1:0]        r_ctrl;
    logic [TAPE_W-1:0] r_tape;
    logic [HEAD_W-1:0] r_head;
    logic [1:0]        r_state;
    logic [STEP_W-1:0] r_steps;
    logic [1:0]        r_status;
    logic [5:0]        r_tbl [0:7];

    logic              w_sym;
    logic [5:0]        w_rule;
    logic              w_halt;
    logic [1:0]        w_move;
    logic              w_wr;
    logic [1:0]        w_nxt;
    logic [STEP_W-1:0] w_steps_nxt;
    logic [HEAD_W-1:0] w_head_nxt;
    logic              w_off;
    logic              w_timeout;

    assign w_sym  = r_tape[r_head];
    assign w_rule = r_tbl[{r_state, w_sym}];
    assign w_halt = w_rule[5];
    assign w_move = w_rule[4:3];
    assign w_wr   = w_rule[2];
    assign w_nxt  = w_rule[1:0];

    assign w_steps_nxt = (r_steps == c_steps_max) ? r_steps : r_steps + 1'b1;
    assign w_off = ((w_move == c_mv_right) && (r_head == c_head_max)) ||
                   ((w_move == c_mv_left)  && (r_head == '0));

    always_comb begin
        w_head_nxt = r_head;
        if (w_move == c_mv_right) begin
            w_head_nxt = r_head + 1'b1;
        end else if (w_move == c_mv_left) begin
            w_head_nxt = r_head - 1'b1;
        end
    end

`ifdef TURING_STEP_LIMIT_EN
    logic [STEP_W-1:0] r_max;

    // A zero limit means the job may run forever.
    assign w_timeout = (r_max != '0) && (w_steps_nxt == r_max);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_max <= '0;
        end else if ((r_ctrl == c_ctrl_idle) && start_valid) begin
            r_max <= start_max_steps;
        end
    end
`else
    logic w_unused_max;

    assign w_timeout    = 1'b0;
    assign w_unused_max = ^start_max_steps;
`endif

    // Rule table; frozen while a job is running.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tbl[0] <= 6'b001000;
            r_tbl[1] <= 6'b001101;
            r_tbl[2] <= 6'b001110;
            r_tbl[3] <= 6'b001101;
            r_tbl[4] <= 6'b010011;
            r_tbl[5] <= 6'b001110;
            r_tbl[6] <= 6'b100000;
            r_tbl[7] <= 6'b000000;
        end else if (tbl_we && (r_ctrl != c_ctrl_run)) begin
            r_tbl[tbl_addr] <= tbl_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl   <= c_ctrl_idle;
            r_tape   <= '0;
            r_head   <= '0;
            r_state  <= 2'b00;
            r_steps  <= '0;
            r_status <= c_stat_halt;
        end else begin
            case (r_ctrl)
                c_ctrl_idle: begin
                    if (start_valid) begin
                        r_tape   <= start_tape;
                        r_head   <= start_head;
                        r_state  <= 2'b00;
                        r_steps  <= '0;
                        r_status <= c_stat_halt;
                        r_ctrl   <= c_ctrl_run;
                    end
                end
                c_ctrl_run: begin
                    if (w_halt) begin
                        r_status <= c_stat_halt;
                        r_ctrl   <= c_ctrl_done;
                    end else begin
                        r_tape[r_head] <= w_wr;
                        r_state        <= w_nxt;
                        r_steps        <= w_steps_nxt;
                        // Off-tape outranks timeout; the head stays put.
                        if (w_off) begin
                            r_status <= c_stat_off;
                            r_ctrl   <= c_ctrl_done;
                        end else begin
                            r_head <= w_head_nxt;
                            if (w_timeout) begin
                                r_status <= c_stat_tmo;
                                r_ctrl   <= c_ctrl_done;
                            end
                        end
                    end
                end
                c_ctrl_done: begin
                    if (res_ready) begin
                        r_ctrl <= c_ctrl_idle;
                    end
                end
                default: r_ctrl <= c_ctrl_idle;
            endcase
        end
    end

    assign start_ready = (r_ctrl == c_ctrl_idle);
    assign busy        = (r_ctrl == c_ctrl_run);
    assign res_valid   = (r_ctrl == c_ctrl_done);
    assign res_tape    = r_tape;
    assign res_head    = r_head;
    assign res_state   = r_state;
    assign res_steps   = r_steps;
    assign res_status  = r_status;

endmodule
`default_nettype wire

// File: tb/tb_turing_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_turing_seq_ctrl                                           |
// | Description : Scoreboard testbench for turing_seq_ctrl.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_turing_seq_ctrl;

    typedef struct {
        logic [15:0] tape;
        logic [3:0]  head;
        logic [1:0]  state;
        logic [7:0]  steps;
        logic [1:0]  status;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [15:0] start_tape;
    logic [3:0]  start_head;
    logic [7:0]  start_max_steps;
    logic        tbl_we;
    logic [2:0]  tbl_addr;
    logic [5:0]  tbl_data;
    logic        busy;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_tape;
    logic [3:0]  res_head;
    logic [1:0]  res_state;
    logic [7:0]  res_steps;
    logic [1:0]  res_status;

    int   n_checks;
    int   n_fail;
    exp_t exp_q[$];
    logic [5:0] mtbl [0:7];

    turing_seq_ctrl #(.HEAD_W(4), .STEP_W(8)) dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready),
        .start_tape(start_tape), .start_head(start_head),
        .start_max_steps(start_max_steps),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_tape(res_tape), .res_head(res_head), .res_state(res_state),
        .res_steps(res_steps), .res_status(res_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_default_tbl();
        mtbl[0] = 6'b001000; mtbl[1] = 6'b001101;
        mtbl[2] = 6'b001110; mtbl[3] = 6'b001101;
        mtbl[4] = 6'b010011; mtbl[5] = 6'b001110;
        mtbl[6] = 6'b100000; mtbl[7] = 6'b000000;
    endtask

    // Reference machine: steps the tape until a terminal condition is hit.
    function automatic exp_t model_run(input logic [15:0] tape_in, input logic [3:0] head_in,
                                       input logic [7:0] maxs);
        exp_t        e;
        logic [15:0] tape;
        logic [3:0]  head;
        logic [5:0]  rule;
        logic [1:0]  st;
        logic [7:0]  steps;
        logic        fin;
`ifndef TURING_STEP_LIMIT_EN
        logic [7:0]  unused_maxs;
        unused_maxs = maxs;
`endif
        tape = tape_in; head = head_in; st = 2'b00; steps = 8'd0; fin = 1'b0;
        e.status = 2'b11;
        for (int i = 0; i < 2000 && !fin; i++) begin
            rule = mtbl[{st, tape[head]}];
            if (rule[5]) begin
                e.status = 2'b00;
                fin = 1'b1;
            end else begin
                tape[head] = rule[2];
                st = rule[1:0];
                if (steps != 8'hFF) steps = steps + 8'd1;
                if ((rule[4:3] == 2'b01 && head == 4'd15) || (rule[4:3] == 2'b10 && head == 4'd0)) begin
                    e.status = 2'b01;
                    fin = 1'b1;
                end else begin
                    if (rule[4:3] == 2'b01) head = head + 4'd1;
                    else if (rule[4:3] == 2'b10) head = head - 4'd1;
`ifdef TURING_STEP_LIMIT_EN
                    if (maxs != 8'd0 && steps == maxs) begin
                        e.status = 2'b10;
                        fin = 1'b1;
                    end
`endif
                end
            end
        end
        e.tape = tape; e.head = head; e.state = st; e.steps = steps;
        return e;
    endfunction

    task automatic tbl_write(input logic [2:0] addr, input logic [5:0] data, input bit upd_model);
        tbl_we = 1'b1; tbl_addr = addr; tbl_data = data;
        tick();
        tbl_we = 1'b0;
        if (upd_model) mtbl[addr] = data;
    endtask

    task automatic drive_job(input logic [15:0] tape, input logic [3:0] head, input logic [7:0] maxs);
        start_valid = 1'b1; start_tape = tape; start_head = head; start_max_steps = maxs;
        tick();
        start_valid = 1'b0;
        check("accept_busy", busy, 1);
    endtask

    task automatic start_job(input logic [15:0] tape, input logic [3:0] head, input logic [7:0] maxs);
        exp_q.push_back(model_run(tape, head, maxs));
        drive_job(tape, head, maxs);
    endtask

    task automatic collect(input string tag, input int hold);
        exp_t e;
        int   n;
        n = 0;
        while (!res_valid && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, res_valid, 1);
        check({tag, "_sb"}, exp_q.size() != 0, 1);
        if (res_valid && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_tape"}, res_tape, e.tape);
            check({tag, "_head"}, res_head, e.head);
            check({tag, "_state"}, res_state, e.state);
            check({tag, "_steps"}, res_steps, e.steps);
            check({tag, "_status"}, res_status, e.status);
            for (int k = 0; k < hold; k++) begin
                tick();
                check({tag, "_hold_valid"}, res_valid, 1);
                check({tag, "_hold_ready"}, start_ready, 0);
                check({tag, "_hold_tape"}, res_tape, e.tape);
                check({tag, "_hold_steps"}, res_steps, e.steps);
                check({tag, "_hold_status"}, res_status, e.status);
            end
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            check({tag, "_idle_ready"}, start_ready, 1);
            check({tag, "_idle_valid"}, res_valid, 0);
        end else if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        exp_t e;
        logic [15:0] rtape;
        n_checks = 0; n_fail = 0;
        rst = 1'b1; start_valid = 1'b0; start_tape = '0; start_head = '0;
        start_max_steps = '0; tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0; res_ready = 1'b0;
        model_default_tbl();
        tick();
        tick();
        check("rst_start_ready", start_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_tape", res_tape, 0);
        check("rst_head", res_head, 0);
        check("rst_state", res_state, 0);
        check("rst_steps", res_steps, 0);
        check("rst_status", res_status, 0);
        rst = 1'b0;
        tick();

        // Reference walk with known answer.
        e.tape = 16'h01F0; e.head = 4'd15; e.state = 2'b00; e.steps = 8'd19; e.status = 2'b01;
        exp_q.push_back(e);
        drive_job(16'h03B0, 4'd0, 8'd0);
        collect("walk", 0);

        // Halt on the very first lookup.
        tbl_write(3'd0, 6'b100000, 1'b1);
        e.tape = 16'h0000; e.head = 4'd3; e.state = 2'b00; e.steps = 8'd0; e.status = 2'b00;
        exp_q.push_back(e);
        drive_job(16'h0000, 4'd3, 8'd0);
        check("halt_lat_edge1", res_valid, 0);
        tick();
        check("halt_lat_edge2", res_valid, 1);
        collect("halt", 0);
        tbl_write(3'd0, 6'b001000, 1'b1);

        // Step limit vs off-tape, with a long backpressure hold.
`ifdef TURING_STEP_LIMIT_EN
        e.tape = 16'h0000; e.head = 4'd5; e.state = 2'b00; e.steps = 8'd5; e.status = 2'b10;
`else
        e.tape = 16'h0000; e.head = 4'd15; e.state = 2'b00; e.steps = 8'd16; e.status = 2'b01;
`endif
        exp_q.push_back(e);
        drive_job(16'h0000, 4'd0, 8'd5);
        collect("limit", 10);

        for (int j = 0; j < 4; j++) begin
            rtape = 16'($urandom);
            start_job(rtape, 4'($urandom_range(0, 15)), 8'd0);
            collect("rand", 1);
        end

        // Table writes while running must be dropped.
        start_job(16'h0000, 4'd0, 8'd0);
        tbl_we = 1'b1; tbl_addr = 3'd0; tbl_data = 6'b100000;
        tick(); tick(); tick();
        tbl_we = 1'b0;
        collect("run_we", 0);
        start_job(16'h0000, 4'd0, 8'd0);
        collect("run_we_after", 0);

        // Reset while a job is in flight.
        drive_job(16'h0000, 4'd0, 8'd0);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        check("midrst_ready", start_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_valid", res_valid, 0);
        check("midrst_steps", res_steps, 0);
        check("midrst_head", res_head, 0);
        rst = 1'b0;
        exp_q.delete();
        model_default_tbl();
        tick();

        // Reset restores the default rule table.
        tbl_write(3'd0, 6'b100000, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_default_tbl();
        tick();
        start_job(16'h0000, 4'd0, 8'd0);
        collect("tbl_restore", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
